// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter.
// Serialises one DATA_BITS word per frame onto serial_out, LSB first:
// start bit (0), data, optional parity bit, STOP_BITS stop bits (1).
// Each bit lasts CLKS_PER_BIT clk cycles. A word is accepted with a
// valid/ready handshake while idle; tx_done pulses for one cycle when the
// last stop bit has completed.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_out
);

    // Reject illegal configurations while the design is being elaborated.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != 0);
    localparam bit               ODD_PARITY = (PARITY == 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 bit_end;

    // The current bit period finishes at the coming edge.
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign tx_busy = ~tx_ready;

    // Baud counter: held at zero while idle, wraps at every bit boundary.
    // NOTE: reset here is synchronous (sampled at posedge), so rstn sits in the
    // body of the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn || state == ST_IDLE) begin
            baud_cnt <= '0;
        end else if (bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Frame sequencer: accepts a word, then walks start/data/parity/stop bits,
    // driving the registered line value for the bit that begins at each boundary.
    // NOTE: every register here uses <= so all of them update from the values
    // seen before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    serial_out <= 1'b1;
                    if (tx_valid) begin
                        state      <= ST_START;
                        shift_reg  <= tx_data;
                        parity_bit <= ODD_PARITY ? ~^tx_data : ^tx_data;
                        serial_out <= 1'b0;
                        bit_idx    <= '0;
                        tx_ready   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state      <= ST_DATA;
                        serial_out <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                        bit_idx    <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (HAS_PARITY) begin
                                state      <= ST_PARITY;
                                serial_out <= parity_bit;
                            end else begin
                                state      <= ST_STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            serial_out <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state      <= ST_STOP;
                        serial_out <= 1'b1;
                        bit_idx    <= '0;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            state      <= ST_IDLE;
                            bit_idx    <= '0;
                            tx_ready   <= 1'b1;
                            tx_done    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    bit_idx    <= '0;
                    serial_out <= 1'b1;
                    tx_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
